// File: rtl/smac_serial_acc.sv
// Weight-serial signed multiply-accumulate: one weight bit per valid cycle, LSB first.
// The finished product is added into a wrapping signed accumulator.
module smac_serial_acc #(
  parameter int Pa    = 8,
  parameter int Pw    = 8,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [Pa-1:0]    act,
  input  logic [1:0]              par_sel_Pw,
  input  logic                    w_valid,
  input  logic                    w_bit,
  input  logic                    acc_clear,
  output logic                    cnt_clear,
  output logic                    w_cnt,
  output logic                    busy,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] acc
);

  localparam int PW_TOT = Pa + Pw;
  localparam int KW     = (Pw > 1) ? $clog2(Pw) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state;
  logic signed [Pa-1:0]      act_q;
  logic [KW-1:0]             k;
  logic [KW-1:0]             k_last;
  logic [KW-1:0]             k_last_sel;
  logic signed [PW_TOT-1:0]  p;
  logic signed [PW_TOT-1:0]  act_ext;
  logic signed [PW_TOT-1:0]  addend;
  logic signed [ACC_W-1:0]   p_ext;
  logic signed [ACC_W-1:0]   acc_base;

  // Index of the sign bit for the selected weight width (4, 6 or full width).
  always_comb begin
    k_last_sel = KW'(Pw - 1);
    case (par_sel_Pw)
      2'b00:   k_last_sel = KW'(3);
      2'b01:   k_last_sel = KW'(5);
      default: k_last_sel = KW'(Pw - 1);
    endcase
  end

  assign act_ext  = PW_TOT'(act_q);
  assign addend   = act_ext <<< k;
  assign p_ext    = ACC_W'(p);
  assign acc_base = acc_clear ? '0 : acc;
  assign w_cnt    = (state == RUN) && w_valid;
  assign busy     = (state != IDLE);

  // The MSB weight bit carries negative weight, so it is subtracted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      act_q     <= '0;
      k         <= '0;
      k_last    <= '0;
      p         <= '0;
      acc       <= '0;
      cnt_clear <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      cnt_clear <= 1'b0;
      out_valid <= 1'b0;
      if (acc_clear && state != DONE)
        acc <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            act_q     <= act;
            k_last    <= k_last_sel;
            p         <= '0;
            k         <= '0;
            cnt_clear <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (w_valid) begin
            if (k == k_last) begin
              if (w_bit)
                p <= p - addend;
              k     <= '0;
              state <= DONE;
            end else begin
              if (w_bit)
                p <= p + addend;
              k <= k + 1'b1;
            end
          end
        end
        DONE: begin
          acc       <= acc_base + p_ext;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smac_serial_acc.sv
// Randomized self-checking bench for smac_serial_acc against an arithmetic
// model (acc = running sum of act * signed weight, modulo 2^24).
module tb_smac_serial_acc;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [7:0]  act;
  logic [1:0]         par_sel_Pw;
  logic               w_valid;
  logic               w_bit;
  logic               acc_clear;
  logic               cnt_clear;
  logic               w_cnt;
  logic               busy;
  logic               out_valid;
  logic signed [23:0] acc;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] acc_model;
  int          cnt_clear_pulses = 0;
  int          wcnt_cycles = 0;

  always #5 clk = ~clk;

  smac_serial_acc #(.Pa(8), .Pw(8), .ACC_W(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .act        (act),
    .par_sel_Pw (par_sel_Pw),
    .w_valid    (w_valid),
    .w_bit      (w_bit),
    .acc_clear  (acc_clear),
    .cnt_clear  (cnt_clear),
    .w_cnt      (w_cnt),
    .busy       (busy),
    .out_valid  (out_valid),
    .acc        (acc)
  );

  always @(posedge clk) begin
    if (cnt_clear) cnt_clear_pulses++;
    if (w_cnt)     wcnt_cycles++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, observed, observed, expected, expected);
    end
  endtask

  function automatic int wsext(input int w, input int n);
    int v;
    v = w & ((1 << n) - 1);
    if (v[n-1]) v = v - (1 << n);
    return v;
  endfunction

  // One full multiply; stalls and stray start/acc_clear are injected mid-run.
  task automatic applyStimulus(input int a, input int sel, input int w, input int stall_pct,
                               input int force_bit, input int force_n, input int clr_run_pct,
                               input bit clr_done);
    int n, prod, wc0, cc0, ns;
    n    = (sel == 0) ? 4 : (sel == 1) ? 6 : 8;
    prod = a * wsext(w, n);
    wc0  = wcnt_cycles;
    cc0  = cnt_clear_pulses;
    act = 8'(a); par_sel_Pw = 2'(sel); start = 1'b1;
    tick;
    start = 1'b0; act = 8'($urandom); par_sel_Pw = 2'($urandom);
    checkOutput("cnt_clear", {31'b0, cnt_clear}, 1);
    checkOutput("busy_run", {31'b0, busy}, 1);
    for (int i = 0; i < n; i++) begin
      ns = (i == force_bit) ? force_n : 0;
      if (stall_pct > 0 && $urandom_range(99) < stall_pct) ns += $urandom_range(1, 3);
      repeat (ns) begin
        w_valid = 1'b0; w_bit = 1'($urandom); start = 1'($urandom);
        acc_clear = ($urandom_range(99) < clr_run_pct);
        #1;
        checkOutput("w_cnt_stall", {31'b0, w_cnt}, 0);
        checkOutput("out_valid_run", {31'b0, out_valid}, 0);
        tick;
        if (acc_clear) acc_model = '0;
        acc_clear = 1'b0; start = 1'b0;
        checkOutput("acc_run", {8'b0, acc}, {8'b0, acc_model});
      end
      w_valid = 1'b1; w_bit = 1'((w >> i) & 1); start = 1'($urandom);
      #1;
      checkOutput("w_cnt_bit", {31'b0, w_cnt}, 1);
      tick;
      start = 1'b0;
    end
    // DONE cycle: w_valid and start must be ignored here
    w_valid = 1'($urandom); start = 1'($urandom); acc_clear = clr_done;
    #1;
    checkOutput("w_cnt_done", {31'b0, w_cnt}, 0);
    checkOutput("busy_done", {31'b0, busy}, 1);
    checkOutput("out_valid_pre", {31'b0, out_valid}, 0);
    tick;
    acc_model = clr_done ? 24'(prod) : acc_model + 24'(prod);
    w_valid = 1'b0; start = 1'b0; acc_clear = 1'b0;
    checkOutput("out_valid", {31'b0, out_valid}, 1);
    checkOutput("acc", {8'b0, acc}, {8'b0, acc_model});
    checkOutput("busy_idle", {31'b0, busy}, 0);
    checkOutput("w_cnt_count", wcnt_cycles - wc0, n);
    checkOutput("cnt_clear_count", cnt_clear_pulses - cc0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; w_valid = 1'b0; w_bit = 1'b0; acc_clear = 1'b0;
    act = '0; par_sel_Pw = '0; acc_model = '0;
    tick; tick;
    checkOutput("rst_acc", {8'b0, acc}, 0);
    checkOutput("rst_busy", {31'b0, busy}, 0);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 0);
    checkOutput("rst_cnt_clear", {31'b0, cnt_clear}, 0);
    rst = 1'b0;

    // Directed cases: 3*5, then -2*-5, then -128*-32 with a 3-cycle stall
    applyStimulus(3, 2, 8'h05, 0, -1, 0, 0, 1'b0);
    checkOutput("acc_15", {8'b0, acc}, 15);
    applyStimulus(-2, 0, 4'b1011, 0, -1, 0, 0, 1'b0);
    checkOutput("acc_25", {8'b0, acc}, 25);
    applyStimulus(-128, 1, 6'b100000, 0, 3, 3, 0, 1'b0);
    checkOutput("acc_4121", {8'b0, acc}, 4121);

    // Clear, build 100, then clear-in-DONE with 7 * -1
    acc_clear = 1'b1;
    tick;
    acc_clear = 1'b0; acc_model = '0;
    checkOutput("acc_clear_idle", {8'b0, acc}, 0);
    applyStimulus(10, 2, 10, 0, -1, 0, 0, 1'b0);
    checkOutput("acc_100", {8'b0, acc}, 100);
    applyStimulus(7, 2, 8'hFF, 0, -1, 0, 0, 1'b1);
    checkOutput("acc_minus7", {8'b0, acc}, 24'hFFFFF9);

    // Reset after 3 of 8 bits, with competing inputs held high
    act = 8'sd5; par_sel_Pw = 2'd2; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) begin
      w_valid = 1'b1; w_bit = 1'b1;
      tick;
    end
    rst = 1'b1; w_valid = 1'b1; start = 1'b1; acc_clear = 1'b0;
    tick;
    rst = 1'b0; w_valid = 1'b0; start = 1'b0; acc_model = '0;
    checkOutput("midrst_busy", {31'b0, busy}, 0);
    checkOutput("midrst_acc", {8'b0, acc}, 0);
    checkOutput("midrst_out_valid", {31'b0, out_valid}, 0);
    checkOutput("midrst_cnt_clear", {31'b0, cnt_clear}, 0);
    applyStimulus(-7, 1, 6'b010110, 0, -1, 0, 0, 1'b0);

    // Random operations with stalls and occasional clears
    repeat (60) begin
      applyStimulus($signed(8'($urandom)), $urandom_range(3), $urandom_range(255), 30, -1, 0, 5,
                    ($urandom_range(9) == 0));
    end

    // Wrap: 127*127 repeated past 2^24
    acc_clear = 1'b1;
    tick;
    acc_clear = 1'b0; acc_model = '0;
    repeat (1100) applyStimulus(127, 2, 127, 5, -1, 0, 0, 1'b0);
    checkOutput("acc_wrapped", {8'b0, acc}, {8'b0, 24'(1100 * 16129)});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/smac_serial_acc.md
SMAC_SERIAL_ACC -- requirements
Module: smac_serial_acc

Interface
REQ-001 Parameter Pa, default 8: activation width, signed two's complement.
REQ-002 Parameter Pw, default 8: maximum weight width; par_sel_Pw selects the active width.
REQ-003 Parameter ACC_W, default 24: accumulator width; ACC_W SHALL be at least Pa+Pw.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  begins one weight-serial multiply; sampled only in IDLE.
REQ-007 act  input  Pa  signed activation; sampled with start.
REQ-008 par_sel_Pw  input  2  weight width: 00 = 4, 01 = 6, 10 = 8, 11 = 8; sampled with start.
REQ-009 w_valid  input  1  w_bit carries a valid weight bit this cycle.
REQ-010 w_bit  input  1  serial weight bit, LSB first, two's complement.
REQ-011 acc_clear  input  1  synchronous accumulator clear.
REQ-012 cnt_clear  output  1  one-cycle pulse when start is accepted; re-initialises the bit-position counter.
REQ-013 w_cnt  output  1  combinational; equals w_valid while in RUN, else 0; advances the bit-position counter.
REQ-014 busy  output  1  high in RUN and DONE.
REQ-015 out_valid  output  1  one-cycle pulse; acc is updated with a new product on that edge.
REQ-016 acc  output  ACC_W  signed running sum of products.

Function
REQ-017 FSM states: IDLE, RUN, DONE.
REQ-018 IDLE -> RUN when start=1.
- Latch act and width N (4/6/8).
- Clear the partial product P (Pa+Pw bits, signed) and the bit index k.
- Pulse cnt_clear.
REQ-019 start SHALL be ignored in RUN and DONE.
REQ-020 In RUN, each w_valid=1 cycle processes one bit:
- k<N-1: P += w_bit ? (sext(act) << k) : 0.
- k=N-1 (MSB): P -= w_bit ? (sext(act) << k) : 0.
- Then k increments.
REQ-021 In RUN, w_valid=0 SHALL hold P and k unchanged (stall); there is no timeout.
REQ-022 RUN -> DONE on the edge that processes bit k=N-1.
REQ-023 DONE lasts exactly one cycle:
- acc <= acc + sext(P), wrapping modulo 2^ACC_W.
- out_valid=1.
- Next state IDLE.
REQ-024 A start in the cycle after DONE (state IDLE) SHALL be accepted, giving back-to-back operation.
REQ-025 Latency: out_valid rises 1 cycle after the edge that processes the MSB; total cycles from start = N + 1 + stall cycles.
REQ-026 acc_clear=1 outside DONE: acc <= 0.
REQ-027 acc_clear=1 in DONE: acc <= sext(P), i.e. clear is applied before the add; out_valid still pulses.
REQ-028 acc_clear SHALL NOT affect FSM state, P or k.
REQ-029 P SHALL equal the exact signed product act*w for all N and all operand values (no overflow within Pa+Pw bits).
REQ-030 w_valid in IDLE or DONE SHALL be ignored and w_cnt SHALL stay 0.

Reset
REQ-031 rst=1 at a clock edge forces:
- state IDLE;
- P=0, k=0, acc=0;
- cnt_clear=0, out_valid=0, busy=0.
REQ-032 rst SHALL take priority over start, acc_clear and w_valid, including mid-RUN; no partial product is added to acc.
REQ-033 The first start SHALL be accepted in the first cycle after rst deasserts.

Verification
REQ-034 act=3, par_sel_Pw=10, w=0x05 sent over 8 consecutive valid cycles -> out_valid 9 cycles after start; acc=15; w_cnt high for exactly 8 cycles.
REQ-035 After REQ-034 with no clear: act=-2, par_sel_Pw=00, w=4'b1011 (-5) -> acc=25; cnt_clear pulses once per start.
REQ-036 act=-128, par_sel_Pw=01, w=6'b100000 (-32), with w_valid dropped for 3 cycles mid-stream -> product +4096; out_valid 10 cycles after start.
REQ-037 acc=100, then acc_clear asserted in the DONE cycle of act=7, w=8'hFF (-1) -> acc=-7.
REQ-038 rst pulsed after 3 of 8 bits -> next cycle IDLE, acc=0, no out_valid; a new start is accepted immediately.
REQ-039 Run repeated products of act=127, w=127 -> acc wraps modulo 2^24 with no sticky flag; start pulsed during RUN is ignored.
